// File: rtl/left_shift_pipelined_elastic_pkg.sv
// Shared constants and helpers for the elastic pipelined left shifter.
package lshift_pkg;

    localparam int unsigned RADIX   = 4;
    localparam int unsigned DIGIT_W = 2;

    // Number of radix-4 stages needed to cover a shift amount of $clog2(width) bits.
    function automatic int unsigned lshift_stages(input int unsigned width);
        return (int'($clog2(width)) + 1) / 2;
    endfunction

endpackage

// File: rtl/left_shift_pipelined_elastic_if.sv
// Streaming bus of the left shifter: input transfer, output transfer, handshakes.
// LSHIFT_OVERFLOW_EN adds the overflow flag aligned with out/out_valid.
interface left_shift_pipelined_elastic_if #(
    parameter int unsigned WIDTH = 13
);
    localparam int unsigned SW = $clog2(WIDTH);

    logic [WIDTH-1:0] in;
    logic [SW-1:0]    shift;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
`ifdef LSHIFT_OVERFLOW_EN
    logic             overflow;

    modport master (
        output in, shift, in_valid, out_ready,
        input  in_ready, out, out_valid, overflow
    );

    modport slave (
        input  in, shift, in_valid, out_ready,
        output in_ready, out, out_valid, overflow
    );
`else
    modport master (
        output in, shift, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in, shift, in_valid, out_ready,
        output in_ready, out, out_valid
    );
`endif

endinterface

// File: rtl/left_shift_pipelined_elastic_stage.sv
// One radix-4 stage: elastic valid/ready register, digit shift, remaining-digit pass-through.
// With LSHIFT_OVERFLOW_EN a sticky flag collects every '1' bit pushed past the MSB.
module lshift_stage
    import lshift_pkg::*;
#(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned SW    = 4,
    parameter int unsigned POS   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SW-1:0]    up_shift,
`ifdef LSHIFT_OVERFLOW_EN
    input  logic             up_sticky,
    output logic             sticky,
`endif
    input  logic             down_ready,
    output logic             ready_c,
    output logic             take_c,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SW-1:0]    rem_shift
);

    localparam int unsigned   DPOS       = DIGIT_W * POS;
    // Masking the digit in place yields digit * 4^POS directly as the shift amount.
    localparam logic [SW-1:0] DIGIT_MASK = SW'(32'd3 << DPOS);
    // Only the lower digits are still needed by later stages.
    localparam logic [SW-1:0] REM_MASK   = SW'((32'd1 << DPOS) - 32'd1);

    logic [SW-1:0]    amt;
    logic [WIDTH-1:0] data_next;

    // Digit amount and shifted data (amounts >= WIDTH shift everything out).
    always_comb begin
        amt       = up_shift & DIGIT_MASK;
        data_next = up_data << amt;
    end

`ifdef LSHIFT_OVERFLOW_EN
    logic [WIDTH-1:0] keep_mask;
    logic             lost;

    // Bits that survive the shift; anything set outside them is discarded.
    always_comb begin
        keep_mask = {WIDTH{1'b1}} >> amt;
        lost      = |(up_data & ~keep_mask);
    end
`endif

    // Accept when empty or when the current entry moves on in the same cycle.
    assign ready_c = ~valid | down_ready;
    assign take_c  = up_valid & ready_c;

    // Stage register: load on take, drop valid when drained, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid     <= 1'b0;
            data      <= '0;
            rem_shift <= '0;
`ifdef LSHIFT_OVERFLOW_EN
            sticky    <= 1'b0;
`endif
        end else if (take_c) begin
            valid     <= 1'b1;
            data      <= data_next;
            rem_shift <= up_shift & REM_MASK;
`ifdef LSHIFT_OVERFLOW_EN
            sticky    <= up_sticky | lost;
`endif
        end else if (down_ready) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/left_shift_pipelined_elastic.sv
// Elastic pipelined logical left shifter: out = (in << shift) truncated to WIDTH.
// Radix-4 stages, MSB digit first; each stage is a valid/ready register so
// backpressure stalls the pipe and bubbles collapse.
// Optional macro LSHIFT_OVERFLOW_EN: adds the sticky overflow output.
module left_shift_pipelined_elastic
    import lshift_pkg::*;
#(
    parameter int unsigned WIDTH = 13
) (
    input logic                           clk,
    input logic                           reset_n,
    left_shift_pipelined_elastic_if.slave bus
);

    localparam int unsigned SW     = $clog2(WIDTH);
    localparam int unsigned STAGES = lshift_stages(WIDTH);

    logic                         rst_done;
    logic [STAGES-1:0]            stage_valid;
    logic [STAGES-1:0]            stage_ready;
    logic [STAGES-1:0]            stage_take;
    logic [STAGES-1:0][WIDTH-1:0] stage_data;
    logic [STAGES-1:0][SW-1:0]    stage_rem;
    logic [SW-1:0]                tail_rem_unused;
`ifdef LSHIFT_OVERFLOW_EN
    logic [STAGES-1:0]            stage_sticky;
`endif

    // Hold off input acceptance until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic [SW-1:0]    up_shift;
        logic             down_ready;
`ifdef LSHIFT_OVERFLOW_EN
        logic             up_sticky;
`endif

        if (s == 0) begin : g_head
            assign up_valid  = bus.in_valid & rst_done;
            assign up_data   = bus.in;
            assign up_shift  = bus.shift;
`ifdef LSHIFT_OVERFLOW_EN
            assign up_sticky = 1'b0;
`endif
        end else begin : g_body
            assign up_valid  = stage_valid[s-1];
            assign up_data   = stage_data[s-1];
            assign up_shift  = stage_rem[s-1];
`ifdef LSHIFT_OVERFLOW_EN
            assign up_sticky = stage_sticky[s-1];
`endif
        end

        if (s == STAGES - 1) begin : g_last
            assign down_ready = bus.out_ready;
        end else begin : g_mid
            assign down_ready = stage_take[s+1];
        end

        lshift_stage #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .POS   (STAGES - 1 - s)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .up_shift   (up_shift),
`ifdef LSHIFT_OVERFLOW_EN
            .up_sticky  (up_sticky),
            .sticky     (stage_sticky[s]),
`endif
            .down_ready (down_ready),
            .ready_c    (stage_ready[s]),
            .take_c     (stage_take[s]),
            .valid      (stage_valid[s]),
            .data       (stage_data[s]),
            .rem_shift  (stage_rem[s])
        );
    end

    // The last stage has no later digits; its remaining shift is always zero.
    assign tail_rem_unused = stage_rem[STAGES-1];

    // Bus outputs: last stage drives the result, stage 0 drives acceptance.
    assign bus.in_ready  = rst_done & stage_ready[0];
    assign bus.out       = stage_data[STAGES-1];
    assign bus.out_valid = stage_valid[STAGES-1];
`ifdef LSHIFT_OVERFLOW_EN
    assign bus.overflow  = stage_sticky[STAGES-1];
`endif

endmodule

// File: tb/tb_left_shift_pipelined_elastic.sv
// Directed + random bench for the elastic pipelined left shifter (WIDTH=13, 2 stages).
module tb_left_shift_pipelined_elastic;

    localparam int unsigned W = 13;
    localparam int unsigned N_RAND = 1000;

    typedef struct {
        logic [12:0] din;
        logic [3:0]  sh;
        logic [12:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[12];

    left_shift_pipelined_elastic_if #(.WIDTH(W)) bus ();

    left_shift_pipelined_elastic #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovf(input string name, input logic exp);
`ifdef LSHIFT_OVERFLOW_EN
        check(name, 32'(bus.overflow), 32'(exp));
`else
        if (exp === 1'bx) $display("unreachable");
`endif
    endtask

    initial begin
        logic [12:0] q_data[$];
        logic        q_ovf[$];
        int          sent;
        int          rcvd;
        logic        in_fire;
        logic        out_fire;
        logic [31:0] wide;
        logic [12:0] exp_d;
        logic        exp_o;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.in        = '0;
        bus.shift     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{13'h0001, 4'd5,  13'h0020, 1'b0};
        vecs[1]  = '{13'h0001, 4'd12, 13'h1000, 1'b0};
        vecs[2]  = '{13'h1FFF, 4'd13, 13'h0000, 1'b1};
        vecs[3]  = '{13'h1FFF, 4'd14, 13'h0000, 1'b1};
        vecs[4]  = '{13'h1FFF, 4'd15, 13'h0000, 1'b1};
        vecs[5]  = '{13'h1ABC, 4'd0,  13'h1ABC, 1'b0};
        vecs[6]  = '{13'h1800, 4'd1,  13'h1000, 1'b1};
        vecs[7]  = '{13'h0001, 4'd13, 13'h0000, 1'b1};
        vecs[8]  = '{13'h0ABC, 4'd3,  13'h15E0, 1'b1};
        vecs[9]  = '{13'h0003, 4'd11, 13'h1800, 1'b0};
        vecs[10] = '{13'h0007, 4'd11, 13'h1800, 1'b1};
        vecs[11] = '{13'h1234, 4'd4,  13'h0340, 1'b1};

        // Reset state and in_ready release timing.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        check("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

        // Table: single transfers, latency 2, result and overflow.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in       = vecs[i].din;
            bus.shift    = vecs[i].sh;
            bus.in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), 32'(bus.out_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].exp_out));
            check_ovf($sformatf("vec%0d_ovf", i), vecs[i].exp_ovf);
            tick();
        end

        // Backpressure: fill with out_ready=0, then drain in order.
        bus.out_ready = 1'b0;
        bus.in        = 13'h0001;
        bus.shift     = 4'd1;
        bus.in_valid  = 1'b1;
        #1;
        check("bp_accept1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.shift = 4'd2;
        #1;
        check("bp_accept2", 32'(bus.in_ready), 32'd1);
        tick();
        bus.shift = 4'd3;
        #1;
        check("bp_full", 32'(bus.in_ready), 32'd0);
        check("bp_out0", 32'(bus.out), 32'h0002);
        tick();
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        check("bp_hold_out", 32'(bus.out), 32'h0002);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_simul_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_out1", 32'(bus.out), 32'h0004);
        tick();
        check("bp_out2", 32'(bus.out), 32'h0008);
        check("bp_out2_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        check("bp_recover", 32'(bus.in_ready), 32'd1);

        // Random stream against a reference model.
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 20000 && rcvd < int'(N_RAND); cyc++) begin
            if (!bus.in_valid && sent < int'(N_RAND) && $urandom_range(0, 3) != 0) begin
                bus.in       = 13'($urandom);
                bus.shift    = 4'($urandom_range(0, 15));
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            in_fire  = bus.in_valid & bus.in_ready;
            out_fire = bus.out_valid & bus.out_ready;
            if (in_fire) begin
                wide = 32'(bus.in) << bus.shift;
                q_data.push_back(13'(wide));
                q_ovf.push_back((wide >> 13) != 32'd0);
                sent++;
            end
            if (out_fire) begin
                if (q_data.size() == 0) begin
                    check("rand_spurious_out", 32'(bus.out), 32'hFFFF_FFFF);
                end else begin
                    exp_d = q_data.pop_front();
                    exp_o = q_ovf.pop_front();
                    check($sformatf("rand_out%0d", rcvd), 32'(bus.out), 32'(exp_d));
                    check_ovf($sformatf("rand_ovf%0d", rcvd), exp_o);
                end
                rcvd++;
            end
            @(posedge clk);
            #1;
            if (in_fire) bus.in_valid = 1'b0;
        end
        check("rand_received", 32'(rcvd), 32'(N_RAND));
        check("rand_sent", 32'(sent), 32'(N_RAND));
        check("rand_queue_empty", 32'(q_data.size()), 32'd0);

        // Reset mid-stream with two items in flight.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.out_ready = 1'b0;
        bus.in        = 13'h1111;
        bus.shift     = 4'd1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in = 13'h0222;
        tick();
        bus.in_valid = 1'b0;
        check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out", 32'(bus.out), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        bus.in        = 13'h0005;
        bus.shift     = 4'd2;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("mid_no_stale", 32'(bus.out_valid), 32'd0);
        tick();
        check("mid_new_valid", 32'(bus.out_valid), 32'd1);
        check("mid_new_out", 32'(bus.out), 32'h0014);
        check_ovf("mid_new_ovf", 1'b0);
        tick();
        check("mid_empty", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
